vga_sprite_engine: RTL and testbench

//  Avalon-MM VGA peripheral, 640x480 from a 50 MHz clock. Draws a river background:

---
 rtl/vga_sprite_engine.sv | 215 +++++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: 640x480 VGA peripheral, river background
// with fixed-priority square sprites; registers commit at vblank.
module vga_sprite_engine #(
  parameter int NUM_SPRITES = 10,
  parameter int SPRITE_SIZE = 16,
  parameter int NUM_BOUNDS  = 4,
  parameter int ADDR_W      = 7,
  parameter int H_ACTIVE    = 1280,
  parameter int H_SYNC_BEG  = 1312,
  parameter int H_SYNC_END  = 1503,
  parameter int H_TOTAL     = 1600,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC_BEG  = 490,
  parameter int V_SYNC_END  = 491,
  parameter int V_TOTAL     = 525
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n
);
  localparam int NS = NUM_SPRITES;
  localparam int NB = NUM_BOUNDS;
  localparam int SB = 2 + NB;
  localparam logic [ADDR_W-1:0] STAT_ADDR = '1;

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [11:0] land_s_q, land_s_d, water_s_q, water_s_d;
  logic [11:0] land_a_q, land_a_d, water_a_q, water_a_d;
  logic [NB-1:0][9:0]  bnd_s_q, bnd_s_d, bnd_a_q, bnd_a_d;
  logic [NS-1:0][9:0]  sx_s_q, sx_s_d, sx_a_q, sx_a_d;
  logic [NS-1:0][9:0]  sy_s_q, sy_s_d, sy_a_q, sy_a_d;
  logic [NS-1:0]       en_s_q, en_s_d, en_a_q, en_a_d;
  logic [NS-1:0][11:0] col_s_q, col_s_d, col_a_q, col_a_d;
  logic [14:0] frame_q, frame_d;
  logic [15:0] rd_q, rd_d;
  logic [NS-1:0] hit_q, hit_d;
  logic        par_q, par_d;
  // sync bundles are {pixel clk, hs, vs, blank_n}
  logic [3:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [23:0] rgb_q, rgb_d;
  logic [9:0]  px;
  logic [11:0] pix;
  logic        commit, vblank;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[14:12];
  assign px     = hcount_q[10:1];
  assign commit = (hcount_q == '0) && (vcount_q == 10'(V_ACTIVE));
  assign vblank = vcount_q >= 10'(V_ACTIVE);

  // Raster counters: hcount runs at clk, vcount steps at line end
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == 11'(H_TOTAL - 1)) begin
      hcount_d = '0;
      if (vcount_q == 10'(V_TOTAL - 1)) vcount_d = '0;
      else vcount_d = vcount_q + 10'd1;
    end
  end

  // Bus writes only ever touch the shadow set
  always_comb begin
    land_s_d  = land_s_q;
    water_s_d = water_s_q;
    bnd_s_d   = bnd_s_q;
    sx_s_d    = sx_s_q;
    sy_s_d    = sy_s_q;
    en_s_d    = en_s_q;
    col_s_d   = col_s_q;
    if (chipselect && write) begin
      if (address == ADDR_W'(0)) land_s_d = writedata[11:0];
      if (address == ADDR_W'(1)) water_s_d = writedata[11:0];
      for (int i = 0; i < NB; i++)
        if (int'(address) == 2 + i) bnd_s_d[i] = writedata[9:0];
      for (int i = 0; i < NS; i++) begin
        if (int'(address) == SB + 3 * i) sx_s_d[i] = writedata[9:0];
        if (int'(address) == SB + 3 * i + 1) sy_s_d[i] = writedata[9:0];
        if (int'(address) == SB + 3 * i + 2) begin
          en_s_d[i]  = writedata[15];
          col_s_d[i] = writedata[11:0];
        end
      end
    end
  end

  // Active set takes the pre-write shadow at the vblank commit point
  always_comb begin
    land_a_d  = land_a_q;
    water_a_d = water_a_q;
    bnd_a_d   = bnd_a_q;
    sx_a_d    = sx_a_q;
    sy_a_d    = sy_a_q;
    en_a_d    = en_a_q;
    col_a_d   = col_a_q;
    frame_d   = frame_q;
    rd_d      = '0;
    if (commit) begin
      land_a_d  = land_s_q;
      water_a_d = water_s_q;
      bnd_a_d   = bnd_s_q;
      sx_a_d    = sx_s_q;
      sy_a_d    = sy_s_q;
      en_a_d    = en_s_q;
      col_a_d   = col_s_q;
      frame_d   = frame_q + 15'd1;
    end
    if (chipselect && read && address == STAT_ADDR)
      rd_d = {vblank, frame_q};
  end

  // Two-stage pixel pipe: hits/parity, then priority select
  always_comb begin
    hit_d = '0;
    par_d = 1'b0;
    for (int i = 0; i < NB; i++)
      if (bnd_a_q[i] != '0 && bnd_a_q[i] <= px) par_d = ~par_d;
    for (int i = 0; i < NS; i++)
      hit_d[i] = en_a_q[i]
        && ((px - sx_a_q[i]) < 10'(SPRITE_SIZE))
        && ((vcount_q - sy_a_q[i]) < 10'(SPRITE_SIZE));
    sync1_d[3] = hcount_q[0];
    sync1_d[2] = !((hcount_q >= 11'(H_SYNC_BEG))
      && (hcount_q <= 11'(H_SYNC_END)));
    sync1_d[1] = !((vcount_q >= 10'(V_SYNC_BEG))
      && (vcount_q <= 10'(V_SYNC_END)));
    sync1_d[0] = (hcount_q < 11'(H_ACTIVE))
      && (vcount_q < 10'(V_ACTIVE));
    pix = par_q ? water_a_q : land_a_q;
    for (int i = NS - 1; i >= 0; i--)
      if (hit_q[i]) pix = col_a_q[i];
    rgb_d = '0;
    if (sync1_q[0])
      rgb_d = {pix[11:8], pix[11:8], pix[7:4], pix[7:4],
               pix[3:0], pix[3:0]};
    sync2_d = sync1_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcount_q  <= '0;
      vcount_q  <= '0;
      land_s_q  <= '0;
      water_s_q <= 12'h008;
      land_a_q  <= '0;
      water_a_q <= 12'h008;
      bnd_s_q   <= '0;
      bnd_a_q   <= '0;
      sx_s_q    <= '0;
      sx_a_q    <= '0;
      sy_s_q    <= '0;
      sy_a_q    <= '0;
      en_s_q    <= '0;
      en_a_q    <= '0;
      col_s_q   <= '0;
      col_a_q   <= '0;
      frame_q   <= '0;
      rd_q      <= '0;
      hit_q     <= '0;
      par_q     <= 1'b0;
      sync1_q   <= 4'b0110;
      sync2_q   <= 4'b0110;
      rgb_q     <= '0;
    end else begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      land_s_q  <= land_s_d;
      water_s_q <= water_s_d;
      land_a_q  <= land_a_d;
      water_a_q <= water_a_d;
      bnd_s_q   <= bnd_s_d;
      bnd_a_q   <= bnd_a_d;
      sx_s_q    <= sx_s_d;
      sx_a_q    <= sx_a_d;
      sy_s_q    <= sy_s_d;
      sy_a_q    <= sy_a_d;
      en_s_q    <= en_s_d;
      en_a_q    <= en_a_d;
      col_s_q   <= col_s_d;
      col_a_q   <= col_a_d;
      frame_q   <= frame_d;
      rd_q      <= rd_d;
      hit_q     <= hit_d;
      par_q     <= par_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      rgb_q     <= rgb_d;
    end
  end

  assign readdata    = rd_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_CLK     = sync2_q[3];
  assign VGA_HS      = sync2_q[2];
  assign VGA_VS      = sync2_q[1];
  assign VGA_BLANK_n = sync2_q[0];
  assign VGA_SYNC_n  = 1'b0;
endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb_vga_sprite_engine: scoreboard bench with a register/pixel
// reference model; short frames, full-width lines.
module tb_vga_sprite_engine;
  localparam int NS = 10, SS = 16, NB = 4, AW = 7;
  localparam int HT = 1600, HA = 1280, HSB = 1312, HSE = 1503;
  localparam int VA = 6, VSB = 7, VSE = 8, VT = 10;
  localparam int SB = 2 + NB;
  localparam int STAT = (1 << AW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0, chipselect = 1'b0;
  logic write = 1'b0, read = 1'b0;
  logic [AW-1:0] address = '0;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [7:0] vga_r, vga_g, vga_b;
  logic vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  always #5 clk = ~clk;

  vga_sprite_engine #(
    .NUM_SPRITES(NS), .SPRITE_SIZE(SS),
    .NUM_BOUNDS(NB), .ADDR_W(AW),
    .H_ACTIVE(HA), .H_SYNC_BEG(HSB),
    .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_BEG(VSB),
    .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .chipselect(chipselect), .write(write),
    .read(read), .address(address),
    .writedata(writedata), .readdata(readdata),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_CLK(vga_clk), .VGA_HS(vga_hs),
    .VGA_VS(vga_vs), .VGA_BLANK_n(vga_blank_n),
    .VGA_SYNC_n(vga_sync_n)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference register sets
  int sh_land, sh_water, sh_b[NB];
  int sh_x[NS], sh_y[NS], sh_en[NS], sh_col[NS];
  int ac_land, ac_water, ac_b[NB];
  int ac_x[NS], ac_y[NS], ac_en[NS], ac_col[NS];
  int frames = 0;
  int k = 0;

  typedef struct packed {
    int cyc; int x; int y; logic [23:0] rgb;
  } pix_t;
  pix_t pixq[$];
  int hsq[$], vsq[$];
  logic [15:0] rdq[$];

  function automatic logic [23:0] expand(int c);
    logic [3:0] r, g, b;
    r = 4'((c >> 8) & 15);
    g = 4'((c >> 4) & 15);
    b = 4'(c & 15);
    return {r, r, g, g, b, b};
  endfunction

  function automatic logic [23:0] exp_pix(int x, int y);
    int n = 0;
    int c;
    for (int i = 0; i < NB; i++)
      if (ac_b[i] != 0 && ac_b[i] <= x) n++;
    c = (n % 2 == 1) ? ac_water : ac_land;
    for (int i = 0; i < NS; i++)
      if (ac_en[i] != 0
          && ((x - ac_x[i] + 1024) % 1024) < SS
          && ((y - ac_y[i] + 1024) % 1024) < SS)
        return expand(ac_col[i]);
    return expand(c);
  endfunction

  task automatic model_reset();
    sh_land = 0; sh_water = 8;
    for (int i = 0; i < NB; i++) sh_b[i] = 0;
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0;
      sh_en[i] = 0; sh_col[i] = 0;
    end
    ac_land = 0; ac_water = 8;
    ac_b = sh_b; ac_x = sh_x; ac_y = sh_y;
    ac_en = sh_en; ac_col = sh_col;
  endtask

  task automatic apply_write(input int a, input int d);
    int s;
    if (a == 0) sh_land = d & 'hFFF;
    else if (a == 1) sh_water = d & 'hFFF;
    else if (a >= 2 && a < 2 + NB) sh_b[a - 2] = d & 1023;
    else if (a >= SB && a < SB + 3 * NS) begin
      s = (a - SB) / 3;
      case ((a - SB) % 3)
        0: sh_x[s] = d & 1023;
        1: sh_y[s] = d & 1023;
        default: begin
          sh_en[s] = (d >> 15) & 1;
          sh_col[s] = d & 'hFFF;
        end
      endcase
    end
  endtask

  task automatic model_step(input bit cs, input bit wr,
                            input bit rd, input int a,
                            input int d);
    int hc, vc;
    hc = k % HT;
    vc = (k / HT) % VT;
    if (hc < HA && vc < VA)
      pixq.push_back('{k + 2, hc / 2, vc, exp_pix(hc / 2, vc)});
    if (hc == HSB || hc == HSE + 1) hsq.push_back(k + 2);
    if (hc == 0 && (vc == VSB || vc == VSE + 1))
      vsq.push_back(k + 2);
    if (cs && rd)
      rdq.push_back(a == STAT ? {vc >= VA, 15'(frames)} : 16'h0);
    if (hc == 0 && vc == VA) begin
      ac_land = sh_land; ac_water = sh_water; ac_b = sh_b;
      ac_x = sh_x; ac_y = sh_y; ac_en = sh_en; ac_col = sh_col;
      frames = (frames + 1) % 32768;
    end
    if (cs && wr) apply_write(a, d);
  endtask

  task automatic tick(input bit cs = 0, input bit wr = 0,
                      input bit rd = 0, input int a = 0,
                      input int d = 0);
    @(negedge clk);
    reset_n = 1'b1;
    chipselect = cs; write = wr; read = rd;
    address = AW'(a); writedata = 16'(d);
    model_step(cs, wr, rd, a, d);
    k++;
  endtask

  task automatic wr(input int a, input int d);
    tick(1, 1, 0, a, d);
  endtask

  task automatic rd(input int a);
    tick(1, 0, 1, a, 0);
  endtask

  task automatic run_to(input int row, input int col);
    while (((k / HT) % VT) != row || (k % HT) != col) tick();
  endtask

  // monitor bookkeeping
  int pcnt;
  bit live, rd_seen;
  always @(posedge clk) begin
    if (!reset_n) begin
      pcnt <= 0;
      live <= 1'b0;
    end else begin
      pcnt <= pcnt + 1;
      live <= 1'b1;
    end
    rd_seen <= chipselect && read && reset_n;
  end

  initial begin : monitor
    logic prev_hs, prev_vs;
    bit first_hs;
    pix_t p;
    prev_hs = 1'b1; prev_vs = 1'b1; first_hs = 1'b1;
    forever begin
      @(negedge clk);
      if (live) begin
        if (vga_blank_n) begin
          if (pixq.size() == 0) begin
            chk("pix_extra", 32'(pcnt), 32'hFFFFFFFF);
          end else begin
            p = pixq.pop_front();
            chk($sformatf("pix(%0d,%0d)", p.x, p.y),
                {8'h0, vga_r, vga_g, vga_b}, {8'h0, p.rgb});
            chk("pix_time", 32'(pcnt), 32'(p.cyc));
          end
        end else begin
          chk("blank_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        end
        if (pcnt >= 2) chk("vga_clk", 32'(vga_clk), 32'(pcnt % 2));
        chk("sync_n", 32'(vga_sync_n), 32'h0);
        if (vga_hs != prev_hs) begin
          if (hsq.size() == 0) chk("hs_extra", 32'(pcnt), 32'hFFFFFFFF);
          else chk("hs_edge", 32'(pcnt), 32'(hsq.pop_front()));
          if (first_hs && !vga_hs) begin
            chk("first_hs_fall", 32'(pcnt), 32'(HSB + 2));
            first_hs = 1'b0;
          end
        end
        if (vga_vs != prev_vs) begin
          if (vsq.size() == 0) chk("vs_extra", 32'(pcnt), 32'hFFFFFFFF);
          else chk("vs_edge", 32'(pcnt), 32'(vsq.pop_front()));
        end
        prev_hs = vga_hs;
        prev_vs = vga_vs;
        if (rd_seen) begin
          if (rdq.size() == 0) chk("rd_extra", 32'(readdata), 32'hFFFFFFFF);
          else chk("readdata", 32'(readdata), 32'(rdq.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: k=%0d want finish", k);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r, a, lo;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    chk("rst_hs", 32'(vga_hs), 32'h1);
    chk("rst_vs", 32'(vga_vs), 32'h1);
    chk("rst_blank", 32'(vga_blank_n), 32'h0);
    chk("rst_rd", 32'(readdata), 32'h0);
    // frame 0: program the scene (shown from frame 1)
    wr(0, 'hF00); wr(1, 'h00F);
    wr(2, 100); wr(3, 300); wr(4, 0); wr(5, 0);
    wr(SB + 0, 50); wr(SB + 1, 0); wr(SB + 2, 'h80F0);
    wr(SB + 3, 58); wr(SB + 4, 2); wr(SB + 5, 'h8FFF);
    wr(SB + 6, 632); wr(SB + 7, VA - 3); wr(SB + 8, 'h8C3A);
    wr(100, 'hFFFF); wr(STAT, 'h1234);
    rd(STAT); rd(1);
    run_to(VA, 0);
    wr(SB + 9, 200);
    wr(SB + 10, 1); wr(SB + 11, 'h8F0F);
    run_to(VA + 1, 0);
    rd(STAT);
    // frame 1: mid-frame move, clear bounds
    run_to(3, 0);
    wr(SB + 0, 400);
    wr(2, 0); wr(3, 0);
    rd(STAT);
    run_to(VA + 1, 0);
    rd(STAT);
    // frame 2: random traffic
    run_to(0, 0);
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(50, 250)) tick();
      r = $urandom_range(0, 9);
      if (r < 7) begin
        a = (r == 0) ? STAT : $urandom_range(0, SB + 3 * NS + 3);
        lo = $urandom_range(0, 1) ? $urandom_range(0, VA + 4)
                                  : $urandom_range(0, 660);
        wr(a, ($urandom & 'hFC00) | lo);
      end else begin
        rd(r == 9 ? STAT : $urandom_range(0, STAT));
      end
    end
    run_to(VA + 1, 0);
    rd(STAT);
    // frame 3: random config on screen
    run_to(0, 0);
    run_to(VA + 1, 0);
    rd(STAT);
    tick();
    repeat (4) @(negedge clk);
    chk("pix_drain", 32'(pixq.size()), 32'h0);
    chk("hs_drain", 32'(hsq.size()), 32'h0);
    chk("vs_drain", 32'(vsq.size()), 32'h0);
    chk("rd_drain", 32'(rdq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
